// File: rtl/foxtrot_pkg.sv
// Shared types and helpers for the dispatch steering block: buffered entry
// layout, round-robin pick and wakeup-snoop match.
package foxtrot_pkg;

  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int FU_COUNT     = 4;
  localparam int DEPTH        = 2;
  localparam int FU_IDX_BITS  = $clog2(FU_COUNT);
  localparam int PTR_BITS     = $clog2(DEPTH);
  localparam int CNT_BITS     = PTR_BITS + 1;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]                    inst_id;
    logic [31:0]                                inst;
    logic [63:0]                                pc;
    logic [FU_COUNT-1:0]                        fu_mask;
    logic [MAX_OPERANDS-1:0]                    op_valid;
    logic [MAX_OPERANDS-1:0]                    op_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]      op_prn;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]      out_prn;
    logic [MAX_OPERANDS-1:0]                    out_prn_valid;
  } dispatch_entry_t;

  typedef struct packed {
    logic                   found;
    logic [FU_IDX_BITS-1:0] idx;
  } rr_pick_t;

  // Scanning from the highest offset down leaves the closest-to-ptr hit in r.
  function automatic rr_pick_t rr_pick(input logic [FU_COUNT-1:0]    mask,
                                       input logic [FU_IDX_BITS-1:0] ptr);
    rr_pick_t               r;
    logic [FU_IDX_BITS-1:0] cand;
    r = '0;
    for (int i = FU_COUNT - 1; i >= 0; i--) begin
      cand = ptr + FU_IDX_BITS'(i);
      if (mask[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_OPERANDS-1:0] wake_match(
      input logic [MAX_OPERANDS-1:0]                             op_valid,
      input logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               op_prn,
      input logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               set_rdy,
      input logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn);
    logic [MAX_OPERANDS-1:0] m;
    m = '0;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      for (int k = 0; k < FU_COUNT; k++) begin
        if (op_valid[j] && set_rdy[k][j] && (set_prn[k][j] == op_prn[j])) begin
          m[j] = 1'b1;
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/dispatch_steer_rr_arbiter.sv
// Rotating-priority pick over FU_COUNT requesters; owns the rotation pointer,
// which moves just past the granted queue whenever a grant is consumed.
module rr_arbiter
  import foxtrot_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FU_COUNT-1:0]    req,
  input  logic                   advance,
  output logic                   found,
  output logic [FU_IDX_BITS-1:0] grant_idx,
  output logic [FU_COUNT-1:0]    grant_onehot
);

  logic [FU_IDX_BITS-1:0] rr_ptr_r;
  rr_pick_t               pick_s;

  // Combinational grant from the current pointer.
  always_comb begin
    pick_s    = rr_pick(req, rr_ptr_r);
    found     = pick_s.found;
    grant_idx = pick_s.idx;
    if (pick_s.found) begin
      grant_onehot = FU_COUNT'(1) << pick_s.idx;
    end else begin
      grant_onehot = {FU_COUNT{1'b0}};
    end
  end

  // Rotation pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= {FU_IDX_BITS{1'b0}};
    end else if (advance && pick_s.found) begin
      rr_ptr_r <= pick_s.idx + FU_IDX_BITS'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/dispatch_steer.sv
// Buffers renamed instructions and steers each to one eligible issue queue,
// snooping FU wakeups so operand-ready bits are current at insertion.
module dispatch_steer
  import foxtrot_pkg::*;
(
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              flush,
  input  logic                                              inst_valid,
  output logic                                              inst_ready,
  input  logic [INST_ID_BITS-1:0]                           inst_id,
  input  logic [31:0]                                       raw_instr,
  input  logic [63:0]                                       instr_pc,
  input  logic [FU_COUNT-1:0]                               fu_mask,
  input  logic [MAX_OPERANDS-1:0]                           prn_input_valid,
  input  logic [MAX_OPERANDS-1:0]                           prn_input_ready,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             prn_input,
  input  logic [MAX_OPERANDS-1:0]                           prn_output_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             prn_output,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]             set_prn_ready,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
  input  logic [FU_COUNT-1:0]                               iq_queue_ready,
  output logic [FU_COUNT-1:0]                               iq_inst_valid,
  output logic [INST_ID_BITS-1:0]                           iq_inst_id,
  output logic [31:0]                                       iq_raw_instr,
  output logic [63:0]                                       iq_instr_pc,
  output logic [MAX_OPERANDS-1:0]                           iq_prn_input_valid,
  output logic [MAX_OPERANDS-1:0]                           iq_prn_input_ready,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             iq_prn_input,
  output logic [MAX_OPERANDS-1:0]                           iq_prn_output_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             iq_prn_output,
  output logic                                              err_no_fu,
  output logic [31:0]                                       stall_cycles
);

  dispatch_entry_t         fifo_mem_r [DEPTH];
  logic [PTR_BITS-1:0]     wr_ptr_r;
  logic [PTR_BITS-1:0]     rd_ptr_r;
  logic [CNT_BITS-1:0]     count_r;
  logic                    err_no_fu_r;
  logic [31:0]             stall_cycles_r;

  dispatch_entry_t         head_s;
  dispatch_entry_t         new_entry_s;
  logic                    head_valid_s;
  logic [FU_COUNT-1:0]     elig_s;
  logic                    found_s;
  logic [FU_IDX_BITS-1:0]  grant_idx_s;
  logic [FU_COUNT-1:0]     grant_onehot_s;
  logic                    dispatch_s;
  logic                    accept_s;
  logic                    push_s;

  assign inst_ready   = (count_r < CNT_BITS'(DEPTH));
  assign head_valid_s = (count_r != {CNT_BITS{1'b0}});
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign accept_s     = inst_valid && inst_ready && !flush;
  assign push_s       = accept_s && (fu_mask != {FU_COUNT{1'b0}});
  assign dispatch_s   = head_valid_s && found_s && !flush;
  assign err_no_fu    = err_no_fu_r;
  assign stall_cycles = stall_cycles_r;

  // Eligible queues for the head and the one-hot insert strobe.
  always_comb begin
    if (head_valid_s) begin
      elig_s = head_s.fu_mask & iq_queue_ready;
    end else begin
      elig_s = {FU_COUNT{1'b0}};
    end
    if (dispatch_s) begin
      iq_inst_valid = grant_onehot_s;
    end else begin
      iq_inst_valid = {FU_COUNT{1'b0}};
    end
  end

  rr_arbiter u_rr_arbiter (
    .clk          (clk),
    .rst          (rst),
    .req          (elig_s),
    .advance      (dispatch_s),
    .found        (found_s),
    .grant_idx    (grant_idx_s),
    .grant_onehot (grant_onehot_s)
  );

  // Incoming entry, already updated with any wakeup seen on its enqueue edge.
  always_comb begin
    new_entry_s               = '0;
    new_entry_s.inst_id       = inst_id;
    new_entry_s.inst          = raw_instr;
    new_entry_s.pc            = instr_pc;
    new_entry_s.fu_mask       = fu_mask;
    new_entry_s.op_valid      = prn_input_valid;
    new_entry_s.op_prn        = prn_input;
    new_entry_s.out_prn       = prn_output;
    new_entry_s.out_prn_valid = prn_output_valid;
    new_entry_s.op_ready      = prn_input_ready |
                                wake_match(prn_input_valid, prn_input, set_prn_ready, set_prn);
  end

  // Shared payload; ready bits bypass same-cycle wakeups so none are lost.
  always_comb begin
    if (head_valid_s) begin
      iq_inst_id          = head_s.inst_id;
      iq_raw_instr        = head_s.inst;
      iq_instr_pc         = head_s.pc;
      iq_prn_input_valid  = head_s.op_valid;
      iq_prn_input_ready  = head_s.op_ready |
                            wake_match(head_s.op_valid, head_s.op_prn, set_prn_ready, set_prn);
      iq_prn_input        = head_s.op_prn;
      iq_prn_output_valid = head_s.out_prn_valid;
      iq_prn_output       = head_s.out_prn;
    end else begin
      iq_inst_id          = {INST_ID_BITS{1'b0}};
      iq_raw_instr        = 32'h0000_0000;
      iq_instr_pc         = 64'h0000_0000_0000_0000;
      iq_prn_input_valid  = {MAX_OPERANDS{1'b0}};
      iq_prn_input_ready  = {MAX_OPERANDS{1'b0}};
      iq_prn_input        = '0;
      iq_prn_output_valid = {MAX_OPERANDS{1'b0}};
      iq_prn_output       = '0;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_BITS{1'b0}};
      rd_ptr_r <= {PTR_BITS{1'b0}};
      count_r  <= {CNT_BITS{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_BITS{1'b0}};
      rd_ptr_r <= {PTR_BITS{1'b0}};
      count_r  <= {CNT_BITS{1'b0}};
    end else begin
      wr_ptr_r <= push_s     ? wr_ptr_r + PTR_BITS'(1) : wr_ptr_r;
      rd_ptr_r <= dispatch_s ? rd_ptr_r + PTR_BITS'(1) : rd_ptr_r;
      case ({push_s, dispatch_s})
        2'b10:   count_r <= count_r + CNT_BITS'(1);
        2'b01:   count_r <= count_r - CNT_BITS'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage with wakeup snoop; the push write overrides the snoop slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i].op_ready <= fifo_mem_r[i].op_ready |
          wake_match(fifo_mem_r[i].op_valid, fifo_mem_r[i].op_prn, set_prn_ready, set_prn);
      end
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= new_entry_s;
      end
    end
  end

  // Sticky flag for instructions no queue can execute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_no_fu_r <= 1'b0;
    end else if (accept_s && (fu_mask == {FU_COUNT{1'b0}})) begin
      err_no_fu_r <= 1'b1;
    end else begin
      err_no_fu_r <= err_no_fu_r;
    end
  end

  // Saturating count of cycles the head waited with no eligible queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_r <= 32'h0000_0000;
    end else if (head_valid_s && !flush && (elig_s == {FU_COUNT{1'b0}}) &&
                 (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'h0000_0001;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

endmodule

// File: doc/dispatch_steer.md
Name: dispatch_steer

Overview:
Sits between the renamer and the per-FU issue queues. Buffers renamed instructions in a small FIFO and steers each one to exactly one eligible issue queue, rotating round-robin among eligible ready queues. While an instruction is buffered, the block snoops FU wakeup broadcasts so operand-ready bits are never stale when the instruction is inserted into an issue queue.

Parameters:
INST_ID_BITS, 6, instruction id width
PRN_BITS, 6, physical register number width
MAX_OPERANDS, 3, source/destination operand slots per instruction
FU_COUNT, 4, number of issue queues / FUs
DEPTH, 2, FIFO entries (power of 2, at least 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of buffered instructions
inst_valid  in  1  renamer has an instruction
inst_ready  out  1  FIFO can accept
inst_id  in  INST_ID_BITS  instruction id
raw_instr  in  32  encoding
instr_pc  in  64  PC
fu_mask  in  FU_COUNT  queues able to execute this instruction
prn_input_valid  in  [MAX_OPERANDS]x1  source used
prn_input_ready  in  [MAX_OPERANDS]x1  source already produced
prn_input  in  [MAX_OPERANDS]xPRN_BITS  source PRNs
prn_output_valid  in  [MAX_OPERANDS]x1  destination used
prn_output  in  [MAX_OPERANDS]xPRN_BITS  destination PRNs
set_prn_ready  in  [FU_COUNT][MAX_OPERANDS]x1  wakeup strobe
set_prn  in  [FU_COUNT][MAX_OPERANDS]xPRN_BITS  wakeup PRN
iq_queue_ready  in  FU_COUNT  per-queue space available
iq_inst_valid  out  FU_COUNT  one-hot insert strobe
iq_inst_id / iq_raw_instr / iq_instr_pc  out  as inputs  shared payload
iq_prn_input_valid / iq_prn_input_ready / iq_prn_input / iq_prn_output_valid / iq_prn_output  out  as inputs  shared payload
err_no_fu  out  1  sticky: accepted instruction had fu_mask == 0
stall_cycles  out  32  saturating count of head-blocked cycles

Behaviour:
- Reset (rst=0, async): FIFO empty, rd/wr ptrs 0, rr_ptr 0, err_no_fu 0, stall_cycles 0. Consequently iq_inst_valid=0 and inst_ready=1. Payload outputs are 0 when the FIFO is empty.
- inst_ready = (count < DEPTH), from registered count only. A full FIFO with a same-cycle pop still deasserts ready.
- Enqueue on inst_valid && inst_ready at the clock edge. If fu_mask==0, the instruction is discarded (not stored) and err_no_fu is set. err_no_fu is cleared only by reset.
- Head selection, combinational from the head entry: elig = head.fu_mask & iq_queue_ready.
  - grant = first set bit of elig, scanning rr_ptr, rr_ptr+1, ... modulo FU_COUNT.
  - iq_inst_valid = onehot(grant) when the head is valid, elig != 0, and flush=0; otherwise 0.
- Pop whenever any iq_inst_valid bit is high. At that edge, rr_ptr <= (grant+1) mod FU_COUNT. rr_ptr is unchanged when there is no grant.
- Latency: an instruction accepted at edge N can be dispatched in the cycle after N at the earliest. With the FIFO empty, throughput is 1 instruction/cycle.
- Wakeup snoop, every cycle, for every stored entry e, operand j, and FU k: if e.op_valid[j], set_prn_ready[k][j], and set_prn[k][j]==e.op_prn[j], then e.op_ready[j] <= 1.
  - The same match is applied to the incoming instruction on its enqueue edge.
  - On the output, iq_prn_input_ready[j] = stored ready OR same-cycle match (bypass), so a wakeup coinciding with insertion is never lost.
- Simultaneous push and pop when not full: both occur and count is unchanged. Pointers wrap modulo DEPTH.
- flush=1: at the edge the FIFO empties, any enqueue that cycle is dropped, and rr_ptr, err_no_fu and stall_cycles hold. iq_inst_valid is 0 during the flush cycle.
- stall_cycles increments, saturating at 2^32-1, when the head is valid, flush=0, and elig==0.
- Reset asserted mid-operation discards all buffered instructions immediately (async).

Decomposition:
- Shared package foxtrot_pkg: a dispatch_entry_t struct (inst_id, inst, pc, fu_mask, op_valid/op_ready/op_prn, out_prn/out_prn_valid) and a helper function rr_pick(mask, ptr) returning an index plus a found flag.
- Sub-module rr_arbiter (FU_COUNT-wide rotating-priority pick, holds rr_ptr) is natural; the FIFO and snoop logic stay in dispatch_steer.

Test Plan:
- Reset, then push id=5 with fu_mask=4'b0110 and all iq_queue_ready=1 -> next cycle iq_inst_valid=4'b0010 with iq_inst_id=5; rr_ptr becomes 2.
- Push 4 instructions, each fu_mask=4'b1111, all queues ready -> grants in order 0001, 0010, 0100, 1000.
- iq_queue_ready=0, push 3 instructions -> inst_ready=0 after 2 accepts, 3rd held by the renamer; stall_cycles counts each blocked cycle; releasing ready drains both.
- Buffered entry with op_prn[1]=17 not ready; pulse set_prn_ready[2][1] with set_prn[2][1]=17 -> dispatched iq_prn_input_ready[1]=1; the same pulse in the dispatch cycle also gives 1 (bypass).
- Push with fu_mask=0 -> not stored, err_no_fu=1 and stays 1 through later traffic.
- FIFO full, assert flush while a queue is ready -> iq_inst_valid=0 that cycle, count=0 after the edge, inst_ready=1; async reset mid-dispatch clears the outputs immediately.
